// File: rtl/vm_pkg.sv
// rtl/vm_pkg.sv - shared types and constants for the vending dispense controller
package vm_pkg;

  localparam logic [1:0] R0  = 2'b00;
  localparam logic [1:0] R5  = 2'b01;
  localparam logic [1:0] R10 = 2'b10;
  localparam logic [1:0] R15 = 2'b11;

  localparam int TK_PER_COIN = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_VEND,
    S_CHANGE,
    S_FAULT
  } state_t;

  typedef struct packed {
    logic       purchase;
    logic [1:0] ret;
  } evt_t;

  // Number of 5 TK coins to eject for a change code.
  function automatic logic [1:0] coins_for(input logic [1:0] code);
    case (code)
      R5:      coins_for = 2'd1;
      R10:     coins_for = 2'd2;
      R15:     coins_for = 2'd3;
      default: coins_for = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/vm_evt_fifo.sv
// rtl/vm_evt_fifo.sv - event queue; a push into a full queue succeeds when a pop happens in the same cycle
module vm_evt_fifo
  import vm_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  evt_t din,
  input  logic pop,
  output evt_t dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(QDEPTH);

  evt_t           mem [QDEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    cnt;
  logic           do_push;
  logic           do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(QDEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/vm_dispense_ctrl.sv
// rtl/vm_dispense_ctrl.sv - queues vend/change events and drives dispenser and coin ejector handshakes
// Optional VM_COIN_COUNT_EN adds saturating vend_count/coin_count outputs.
module vm_dispense_ctrl
  import vm_pkg::*;
#(
  parameter int QDEPTH  = 4,
  parameter int TIMEOUT = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        purchase,
  input  logic [1:0]  ret,
  output logic        vend_req,
  input  logic        vend_done,
  output logic        coin_eject,
  input  logic        coin_ack,
  input  logic        fault_clr,
  output logic        busy,
  output logic        fault,
  output logic        overflow
`ifdef VM_COIN_COUNT_EN
  ,
  output logic [15:0] vend_count,
  output logic [15:0] coin_count
`endif
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t          state;
  evt_t            evt_in;
  evt_t            head;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  logic [1:0]      coins;
  logic [TW-1:0]   timer;
  logic            timeout_hit;

  assign evt_in.purchase = purchase;
  assign evt_in.ret      = ret;
  assign push            = purchase | (ret != R0);
  assign pop             = (state == S_IDLE) & ~empty;
  assign busy            = (state != S_IDLE) | ~empty;
  assign timeout_hit     = (timer == TW'(TIMEOUT - 1));

  vm_evt_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (evt_in),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      vend_req   <= 1'b0;
      coin_eject <= 1'b0;
      fault      <= 1'b0;
      overflow   <= 1'b0;
      coins      <= '0;
      timer      <= '0;
    end else begin
      overflow <= (overflow & ~fault_clr) | (push & full & ~pop);
      case (state)
        S_IDLE: begin
          if (!empty) begin
            coins <= coins_for(head.ret);
            timer <= '0;
            if (head.purchase) begin
              state    <= S_VEND;
              vend_req <= 1'b1;
            end else if (head.ret != R0) begin
              state      <= S_CHANGE;
              coin_eject <= 1'b1;
            end
          end
        end
        S_VEND: begin
          // A done arriving on the expiry cycle still counts as success.
          if (vend_done) begin
            vend_req <= 1'b0;
            timer    <= '0;
            if (coins != 2'd0) begin
              state      <= S_CHANGE;
              coin_eject <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end else if (timeout_hit) begin
            state    <= S_FAULT;
            vend_req <= 1'b0;
            fault    <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_CHANGE: begin
          if (!coin_eject) begin
            coin_eject <= 1'b1;
            timer      <= '0;
          end else if (coin_ack) begin
            coin_eject <= 1'b0;
            coins      <= coins - 2'd1;
            if (coins == 2'd1) state <= S_IDLE;
          end else if (timeout_hit) begin
            state      <= S_FAULT;
            coin_eject <= 1'b0;
            fault      <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_FAULT: begin
          if (fault_clr) begin
            state <= S_IDLE;
            fault <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef VM_COIN_COUNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vend_count <= '0;
      coin_count <= '0;
    end else begin
      if ((state == S_VEND) && vend_req && vend_done && (vend_count != 16'hFFFF))
        vend_count <= vend_count + 16'd1;
      if ((state == S_CHANGE) && coin_eject && coin_ack && (coin_count != 16'hFFFF))
        coin_count <= coin_count + 16'd1;
    end
  end
`endif

endmodule
